// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: fetches one word per PC, holds it for execute,
// retires or redirects on accept, and raises a one-cycle trap on faults.
module instruction_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    output logic        o_IMemRequest,
    output logic [31:0] o_IMemAddress,
    input  logic        i_IMemReady,
    input  logic [31:0] i_IMemData,
    output logic [31:0] o_InstructionWord,
    output logic [31:0] o_InstructionPC,
    output logic        o_InstructionValid,
    input  logic        i_InstructionAccept,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPC,
    input  logic        i_IllegalInstruction,
    output logic        o_Trap,
    output logic [3:0]  o_TrapCause,
    output logic [31:0] o_TrapPC,
    output logic [31:0] o_InstretCount
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

    logic [1:0]  state_reg,   state_next;
    logic [31:0] pc_reg,      pc_next;
    logic [31:0] word_reg,    word_next;
    logic [31:0] ipc_reg,     ipc_next;
    logic [31:0] instret_reg, instret_next;
    logic [3:0]  cause_reg,   cause_next;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        word_next    = word_reg;
        ipc_next     = ipc_reg;
        instret_next = instret_reg;
        cause_next   = cause_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_IMemReady) begin
                    word_next  = i_IMemData;
                    ipc_next   = pc_reg;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The decoder verdict outranks accept: an illegal word never retires.
                if (i_IllegalInstruction) begin
                    cause_next = CAUSE_ILLEGAL;
                    state_next = ST_TRAP;
                end else if (i_InstructionAccept) begin
                    if (!i_Redirect) begin
                        pc_next      = pc_reg + 32'd4;
                        instret_next = instret_reg + 32'd1;
                        state_next   = ST_FETCH;
                    end else if (i_RedirectPC[1:0] == 2'b00) begin
                        pc_next      = i_RedirectPC;
                        instret_next = instret_reg + 32'd1;
                        state_next   = ST_FETCH;
                    end else begin
                        cause_next = CAUSE_MISALIGNED;
                        state_next = ST_TRAP;
                    end
                end
            end
            ST_TRAP: begin
                pc_next    = TRAP_VECTOR;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            word_reg    <= 32'd0;
            ipc_reg     <= 32'd0;
            instret_reg <= 32'd0;
            cause_reg   <= 4'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            word_reg    <= word_next;
            ipc_reg     <= ipc_next;
            instret_reg <= instret_next;
            cause_reg   <= cause_next;
        end
    end

    // Trap outputs are forced to zero outside the single TRAP cycle.
    assign o_IMemRequest      = (state_reg == ST_FETCH);
    assign o_IMemAddress      = pc_reg;
    assign o_InstructionWord  = word_reg;
    assign o_InstructionPC    = ipc_reg;
    assign o_InstructionValid = (state_reg == ST_ISSUE) && !i_IllegalInstruction;
    assign o_Trap             = (state_reg == ST_TRAP);
    assign o_TrapCause        = (state_reg == ST_TRAP) ? cause_reg : 4'd0;
    assign o_TrapPC           = (state_reg == ST_TRAP) ? ipc_reg : 32'd0;
    assign o_InstretCount     = instret_reg;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: directed scenarios plus an event-level
// fetch/issue model compared against the DUT on every falling edge.
module tb_instruction_fetch_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_IMemRequest;
    logic [31:0] o_IMemAddress;
    logic        ready;
    logic [31:0] data;
    logic [31:0] o_InstructionWord;
    logic [31:0] o_InstructionPC;
    logic        o_InstructionValid;
    logic        accept;
    logic        redirect;
    logic [31:0] rpc;
    logic        illegal;
    logic        o_Trap;
    logic [3:0]  o_TrapCause;
    logic [31:0] o_TrapPC;
    logic [31:0] o_InstretCount;

    int checks = 0;
    int errors = 0;

    instruction_fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .TRAP_VECTOR(TRAP_VECTOR)
    ) dut (
        .i_Clock             (clk),
        .i_Reset             (rst),
        .o_IMemRequest       (o_IMemRequest),
        .o_IMemAddress       (o_IMemAddress),
        .i_IMemReady         (ready),
        .i_IMemData          (data),
        .o_InstructionWord   (o_InstructionWord),
        .o_InstructionPC     (o_InstructionPC),
        .o_InstructionValid  (o_InstructionValid),
        .i_InstructionAccept (accept),
        .i_Redirect          (redirect),
        .i_RedirectPC        (rpc),
        .i_IllegalInstruction(illegal),
        .o_Trap              (o_Trap),
        .o_TrapCause         (o_TrapCause),
        .o_TrapPC            (o_TrapPC),
        .o_InstretCount      (o_InstretCount)
    );

    always #5 clk = ~clk;

    // Decoder stub: the all-zero word is the only illegal encoding.
    assign illegal = (o_InstructionWord == 32'h0);

    logic [31:0] illegal_addr;
    int          mem_wait;
    int          wait_ctr;
    logic        force_ready;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == illegal_addr) ? 32'h0 : a + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and let the memory model answer for the new cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (o_IMemRequest) begin
            ready = (wait_ctr >= mem_wait);
            wait_ctr++;
        end else begin
            ready    = force_ready;
            wait_ctr = 0;
        end
        data = mem_data(o_IMemAddress);
    endtask

    task automatic wait_issue();
        int n = 0;
        while (o_InstructionValid !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        chk("wait_issue_timeout", 32'(n < 50), 32'd1);
    endtask

    // ---------------- behavioural model ----------------
    logic        m_init = 1'b0;
    logic        m_idle, m_hold, m_trap;
    logic [31:0] m_pc, m_word, m_ipc, m_count, m_trap_pc;
    logic [3:0]  m_cause;
    logic        exp_req;
    int          cyc = 0;
    logic [31:0] fetch_addr[$];
    int          fetch_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (m_init) begin
            exp_req = !m_hold && !m_trap && !m_idle;
            chk("req", 32'(o_IMemRequest), 32'(exp_req));
            if (exp_req) chk("addr", o_IMemAddress, m_pc);
            chk("valid", 32'(o_InstructionValid), 32'(m_hold && (m_word != 32'h0)));
            chk("word", o_InstructionWord, m_word);
            chk("ipc", o_InstructionPC, m_ipc);
            chk("trap", 32'(o_Trap), 32'(m_trap));
            chk("cause", 32'(o_TrapCause), m_trap ? 32'(m_cause) : 32'd0);
            chk("trap_pc", o_TrapPC, m_trap ? m_trap_pc : 32'd0);
            chk("instret", o_InstretCount, m_count);
        end
        if (rst) begin
            m_init  = 1'b1;
            m_idle  = 1'b1;
            m_hold  = 1'b0;
            m_trap  = 1'b0;
            m_pc    = RESET_PC;
            m_word  = 32'h0;
            m_ipc   = 32'h0;
            m_count = 32'h0;
        end else if (m_init) begin
            if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_trap) begin
                m_trap = 1'b0;
                m_pc   = TRAP_VECTOR;
            end else if (!m_hold) begin
                if (ready) begin
                    m_word = data;
                    m_ipc  = m_pc;
                    m_hold = 1'b1;
                    fetch_addr.push_back(m_pc);
                    fetch_cyc.push_back(cyc);
                    $display("fetch   pc=%h word=%h", m_pc, data);
                end
            end else if (m_word == 32'h0) begin
                m_hold = 1'b0; m_trap = 1'b1; m_cause = 4'd2; m_trap_pc = m_ipc;
                $display("trap    cause=2 pc=%h", m_ipc);
            end else if (accept) begin
                m_hold = 1'b0;
                if (redirect && rpc[1:0] != 2'b00) begin
                    m_trap = 1'b1; m_cause = 4'd0; m_trap_pc = m_ipc;
                    $display("trap    cause=0 pc=%h target=%h", m_ipc, rpc);
                end else begin
                    m_pc    = redirect ? rpc : m_pc + 32'd4;
                    m_count = m_count + 32'd1;
                    $display("retire  pc=%h next=%h instret=%0d", m_ipc, m_pc, m_count);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] saved_count;
        logic [31:0] a;
        int n;
        rst = 1'b1; accept = 1'b0; redirect = 1'b0; rpc = 32'h0;
        ready = 1'b0; data = 32'h0; force_ready = 1'b0;
        mem_wait = 0; wait_ctr = 0; illegal_addr = 32'h1;

        repeat (3) cycle();
        chk("reset_req", 32'(o_IMemRequest), 32'd0);
        chk("reset_word", o_InstructionWord, 32'h0);
        chk("reset_count", o_InstretCount, 32'h0);
        chk("reset_trap", 32'(o_Trap), 32'd0);

        // Streaming: ready and accept tied high.
        rst = 1'b0; accept = 1'b1;
        cycle();
        chk("first_req", 32'(o_IMemRequest), 32'd1);
        chk("first_addr", o_IMemAddress, 32'h0);
        repeat (6) cycle();
        chk("stream_count", o_InstretCount, 32'd3);
        chk("stream_fetches", 32'(fetch_addr.size()), 32'd3);
        if (fetch_addr.size() >= 3) begin
            chk("stream_a0", fetch_addr[0], 32'h0);
            chk("stream_a1", fetch_addr[1], 32'h4);
            chk("stream_a2", fetch_addr[2], 32'h8);
            chk("stream_gap", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd2);
        end

        // Memory with three wait cycles.
        accept = 1'b0; mem_wait = 3;
        wait_issue();
        accept = 1'b1;
        cycle();
        accept = 1'b0;
        a = o_IMemAddress;
        chk("slow_addr", a, 32'h10);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk("slow_waits", 32'(n), 32'd3);
        cycle();
        chk("slow_word", o_InstructionWord, 32'h23);
        chk("slow_valid", 32'(o_InstructionValid), 32'd1);
        mem_wait = 0;

        // Aligned redirect, then misaligned redirect.
        accept = 1'b1; redirect = 1'b1; rpc = 32'h100;
        cycle();
        accept = 1'b0; redirect = 1'b0;
        chk("redir_addr", o_IMemAddress, 32'h100);
        wait_issue();
        saved_count = o_InstretCount;
        chk("redir_count", saved_count, 32'd5);
        accept = 1'b1; redirect = 1'b1; rpc = 32'h102;
        cycle();
        accept = 1'b0; redirect = 1'b0;
        chk("mis_trap", 32'(o_Trap), 32'd1);
        chk("mis_cause", 32'(o_TrapCause), 32'd0);
        chk("mis_pc", o_TrapPC, 32'h100);
        chk("mis_count", o_InstretCount, 32'd5);
        cycle();
        chk("mis_trap_end", 32'(o_Trap), 32'd0);
        chk("mis_vector", o_IMemAddress, 32'h4);

        // Illegal (all-zero) word fetched at 0x200.
        wait_issue();
        illegal_addr = 32'h200;
        accept = 1'b1; redirect = 1'b1; rpc = 32'h200;
        cycle();
        redirect = 1'b0;
        cycle();
        chk("ill_valid", 32'(o_InstructionValid), 32'd0);
        chk("ill_word", o_InstructionWord, 32'h0);
        cycle();
        accept = 1'b0;
        chk("ill_trap", 32'(o_Trap), 32'd1);
        chk("ill_cause", 32'(o_TrapCause), 32'd2);
        chk("ill_pc", o_TrapPC, 32'h200);
        cycle();
        chk("ill_vector", o_IMemAddress, 32'h4);
        chk("ill_count", o_InstretCount, 32'd6);
        illegal_addr = 32'h1;

        // Held issue: no accept for five cycles.
        wait_issue();
        repeat (5) begin
            chk("hold_valid", 32'(o_InstructionValid), 32'd1);
            chk("hold_word", o_InstructionWord, 32'h17);
            chk("hold_pc", o_InstructionPC, 32'h4);
            cycle();
        end
        // Accept and redirect while fetching must be ignored.
        accept = 1'b1; mem_wait = 2;
        cycle();
        redirect = 1'b1; rpc = 32'h302;
        cycle();
        chk("fetch_acc_addr", o_IMemAddress, 32'h8);
        chk("fetch_acc_count", o_InstretCount, 32'd7);
        cycle();
        redirect = 1'b0;
        cycle();
        chk("fetch_acc_valid", 32'(o_InstructionValid), 32'd1);

        // Reset in the middle of a fetch with a late ready.
        mem_wait = 5;
        n = 0;
        while (o_IMemRequest !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk("midfetch_reach", 32'(o_IMemRequest), 32'd1);
        accept = 1'b0; rst = 1'b1; force_ready = 1'b1; mem_wait = 0;
        cycle();
        rst = 1'b0;
        chk("rst_req_drop", 32'(o_IMemRequest), 32'd0);
        chk("rst_word", o_InstructionWord, 32'h0);
        chk("rst_count", o_InstretCount, 32'h0);
        force_ready = 1'b0;
        cycle();
        chk("rst_restart", o_IMemAddress, RESET_PC);
        chk("rst_restart_req", 32'(o_IMemRequest), 32'd1);

        // PC wrap from 0xFFFF_FFFC to 0.
        wait_issue();
        accept = 1'b1; redirect = 1'b1; rpc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        chk("wrap_addr", o_IMemAddress, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_ipc", o_InstructionPC, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_next", o_IMemAddress, 32'h0);
        chk("wrap_count", o_InstretCount, 32'd2);
        accept = 1'b0;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch_sequencer.md
INSTRUCTION_FETCH_SEQUENCER -- requirements
Module: instruction_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded by reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0004: PC loaded on any trap.
REQ-003 i_Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 o_IMemRequest  out  1  instruction-memory read request.
REQ-006 o_IMemAddress  out  32  word address of request (= PC).
REQ-007 i_IMemReady  in  1  memory response valid; i_IMemData valid this cycle.
REQ-008 i_IMemData  in  32  fetched instruction word.
REQ-009 o_InstructionWord  out  32  latched instruction, drives decoder input.
REQ-010 o_InstructionPC  out  32  PC of o_InstructionWord.
REQ-011 o_InstructionValid  out  1  legal instruction available for execute.
REQ-012 i_InstructionAccept  in  1  execute consumes current instruction.
REQ-013 i_Redirect  in  1  taken branch/jump; qualifies i_RedirectPC.
REQ-014 i_RedirectPC  in  32  next-PC target for redirect.
REQ-015 i_IllegalInstruction  in  1  decoder verdict on o_InstructionWord (combinational).
REQ-016 o_Trap  out  1  one-cycle trap pulse.
REQ-017 o_TrapCause  out  4  0 = misaligned fetch target, 2 = illegal instruction.
REQ-018 o_TrapPC  out  32  PC of offending instruction.
REQ-019 o_InstretCount  out  32  retired-instruction counter.

Function
REQ-020 FSM states: IDLE, FETCH, ISSUE, TRAP; exactly one active per cycle.
REQ-021 IDLE: all handshake outputs 0; next state FETCH unconditionally.
REQ-022 FETCH: o_IMemRequest=1, o_IMemAddress=PC held stable until i_IMemReady=1.
REQ-023 i_IMemReady sampled only in FETCH; zero-wait response (ready in first FETCH cycle) allowed; ready outside FETCH ignored.
REQ-024 FETCH with i_IMemReady=1: latch i_IMemData into o_InstructionWord, PC into o_InstructionPC; next ISSUE.
REQ-025 ISSUE: o_InstructionValid = !i_IllegalInstruction; o_IMemRequest=0.
REQ-026 ISSUE with i_IllegalInstruction=1: next TRAP, cause 2; i_InstructionAccept ignored.
REQ-027 ISSUE, legal, i_InstructionAccept=0: remain ISSUE, word/PC held unchanged.
REQ-028 ISSUE, legal, accept=1, redirect=0: PC <= PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); o_InstretCount += 1; next FETCH.
REQ-029 ISSUE, legal, accept=1, redirect=1, i_RedirectPC[1:0]=00: PC <= i_RedirectPC; counter += 1; next FETCH.
REQ-030 ISSUE, legal, accept=1, redirect=1, i_RedirectPC[1:0]!=00: no retire count; next TRAP, cause 0.
REQ-031 i_Redirect ignored in any cycle without a legal accept in ISSUE.
REQ-032 TRAP: o_Trap=1 for exactly one cycle; o_TrapCause and o_TrapPC (=o_InstructionPC) valid that cycle, 0 otherwise; PC <= TRAP_VECTOR; next FETCH.
REQ-033 o_InstretCount wraps 32'hFFFF_FFFF -> 0.
REQ-034 Minimum throughput with zero-wait memory and immediate accept: one instruction per 2 cycles.

Reset
REQ-035 i_Reset=1 at any edge: state IDLE, PC=RESET_PC, o_InstructionWord=0, o_InstructionPC=0, o_InstretCount=0, all 1-bit outputs 0, o_TrapCause=0, o_TrapPC=0; reset dominates all other inputs.
REQ-036 Reset during FETCH: o_IMemRequest deasserts the following cycle; any late i_IMemReady is discarded.
REQ-037 First request after reset release: cycle 2 (IDLE then FETCH), address RESET_PC.

Verification
REQ-038 Reset release, ready tied 1, accept tied 1, legal words: addresses 0,4,8,... one request every 2 cycles; o_InstretCount=3 after 6 cycles of FETCH/ISSUE.
REQ-039 Memory ready delayed 3 cycles: o_IMemAddress stable and request high for all 3 wait cycles; word latched only on ready cycle.
REQ-040 Accept with redirect to 32'h0000_0100: next request address 32'h100; redirect to 32'h0000_0102: o_Trap pulse, cause 0, TrapPC = jump PC, next fetch at TRAP_VECTOR.
REQ-041 Fetched word 32'h0000_0000 (decoder flags illegal): o_InstructionValid=0, one-cycle o_Trap cause 2, counter unchanged, next fetch 32'h0000_0004.
REQ-042 Accept held 0 for 5 ISSUE cycles: word/PC/valid stable; accept asserted without valid (FETCH/TRAP) has no effect.
REQ-043 Reset asserted mid-FETCH with ready arriving next cycle: request drops, word stays 0, fetch restarts at RESET_PC; PC 32'hFFFF_FFFC retire wraps next fetch to 0.
